// File: rtl/cla32_pkg.sv
// Shared constants and helpers for the two-level carry-lookahead adder.
package cla32_pkg;

  localparam int GROUP_W       = 4;
  localparam int DEFAULT_WIDTH = 32;

  // Number of 4-bit lookahead groups needed for a given operand width.
  function automatic int group_count(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/cla32_cla4.sv
// One 4-bit carry-lookahead group: local sums plus group generate/propagate.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       G,
  output logic       P
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Internal carries are flat sum-of-products, no ripple inside the group.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s = p ^ c;

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

endmodule

// File: rtl/cla32.sv
// Registered WIDTH-bit two-level carry-lookahead adder; Sum[WIDTH] is carry-out.
// Optional carry-in port Cin is enabled by defining CLA32_CIN_EN.
module cla32
  import cla32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CLA32_CIN_EN
  input  logic             Cin,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   Sum
);

  localparam int NG = group_count(WIDTH);

  generate
    if ((WIDTH % GROUP_W) != 0 || WIDTH <= 0) begin : g_width_check
      $error("cla32: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  logic          c0;
  logic [NG-1:0] grp_g;
  logic [NG-1:0] grp_p;
  logic [NG:0]   grp_c;
  logic [WIDTH-1:0] sum_bits;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;
  logic          term;
  logic          acc;

`ifdef CLA32_CIN_EN
  assign c0 = Cin;
`else
  assign c0 = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NG; gi++) begin : g_group
      cla4 u_cla4 (
        .a   (A[gi*GROUP_W +: GROUP_W]),
        .b   (B[gi*GROUP_W +: GROUP_W]),
        .cin (grp_c[gi]),
        .s   (sum_bits[gi*GROUP_W +: GROUP_W]),
        .G   (grp_g[gi]),
        .P   (grp_p[gi])
      );
    end
  endgenerate

  // Second-level lookahead: each group carry is an independent sum of
  // products over lower-group G/P and c0, so no carry ripples between groups.
  always_comb begin
    grp_c    = '0;
    term     = 1'b0;
    acc      = 1'b0;
    grp_c[0] = c0;
    for (int k = 1; k <= NG; k++) begin
      acc = 1'b0;
      for (int j = 0; j < k; j++) begin
        term = grp_g[j];
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_p[m];
        end
        acc = acc | term;
      end
      term = c0;
      for (int m = 0; m < k; m++) begin
        term = term & grp_p[m];
      end
      grp_c[k] = acc | term;
    end
  end

  assign sum_d = {grp_c[NG], sum_bits};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign Sum = sum_q;

endmodule

// File: tb/tb_cla32.sv
// Directed and random checks of cla32 against a behavioural unsigned add.
module tb_cla32;

  logic        clk;
  logic        rst;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cin_in;
  logic [32:0] sum_out;

  int n_tests;
  int n_fail;
  logic [32:0] prev_exp;
  bit          have_prev;

  cla32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
`ifdef CLA32_CIN_EN
    .Cin (cin_in),
`endif
    .A   (a_in),
    .B   (b_in),
    .Sum (sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%09h expected 0x%09h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, confirm Sum is still registered before the
  // edge, then check the new result one edge later.
  task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic r, input bit verbose);
    logic [32:0] exp;
    logic        eff_c;
`ifdef CLA32_CIN_EN
    eff_c = c;
`else
    eff_c = 1'b0 & c;
`endif
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin_in = c;
    rst    = r;
    #1;
    if (have_prev) check({tag, "_hold"}, sum_out, prev_exp);
    exp = r ? 33'd0 : ({1'b0, a} + {1'b0, b} + {32'd0, eff_c});
    @(posedge clk);
    #1;
    check(tag, sum_out, exp);
    prev_exp  = exp;
    have_prev = 1'b1;
    if (verbose)
      $display("[TB] %-8s rst=%0b A=0x%08h B=0x%08h Cin=%0b -> Sum=0x%09h (exp 0x%09h)",
               tag, r, a, b, eff_c, sum_out, exp);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    have_prev = 1'b0;
    prev_exp  = '0;
    rst       = 1'b1;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;

    // Reset loads zero regardless of operands; release yields 5+7.
    apply("rst",     32'd5,   32'd7,  1'b0, 1'b1, 1'b1);
    check("rst_val", sum_out, 33'h000000000);
    apply("rst_rel", 32'd5,   32'd7,  1'b0, 1'b0, 1'b1);
    check("rel_val", sum_out, 33'h00000000C);

    apply("s2_2",    32'd2,   32'd2,  1'b0, 1'b0, 1'b1);
    check("v_4",     sum_out, 33'h004);
    apply("s2_3",    32'd2,   32'd3,  1'b0, 1'b0, 1'b1);
    check("v_5",     sum_out, 33'h005);
    apply("s18_18",  32'd18,  32'd18, 1'b0, 1'b0, 1'b1);
    check("v_24",    sum_out, 33'h024);
    apply("s100_0",  32'd100, 32'd0,  1'b0, 1'b0, 1'b1);
    check("v_64",    sum_out, 33'h064);

    apply("maxcy",   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    check("v_maxcy", sum_out, 33'h1FFFFFFFE);
    apply("fullprop", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1);
    check("v_full",  sum_out, 33'h100000000);
`ifdef CLA32_CIN_EN
    apply("cinprop", 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1);
    check("v_cin",   sum_out, 33'h100000000);
`endif
    // Group-boundary carries: one group ripples into the next.
    apply("grp_bd",  32'h0000000F, 32'h00000001, 1'b0, 1'b0, 1'b1);
    apply("grp_mid", 32'h0FFFF000, 32'h00001000, 1'b0, 1'b0, 1'b1);
    apply("neg1",    32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1);

    // Mid-stream reset discards the in-flight result.
    apply("pre",     32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
    apply("mid_rst", 32'd3, 32'd4, 1'b0, 1'b1, 1'b1);
    apply("post",    32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    check("v_post",  sum_out, 33'h007);

    for (int i = 0; i < 10000; i++) begin
      apply("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
